mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage; contains the EX/MEM register, the data-memory access FSM and the MEM/WB register.
- Takes the ALU result and the forwarded store data from execute.
- Performs loads and stores over a req/ack data-memory handshake and asserts a stall while an access is outstanding.
- Feeds back ex_mem_alu_result and mem_wb_write_back_result to the execute forwarding muxes.

---
 rtl/mem_access_stage_pkg.sv | 15 +
 rtl/mem_access_stage_if.sv | 34 +++
 rtl/mem_access_stage_req_fsm.sv | 100 ++++++++++
 rtl/mem_access_stage.sv | 145 ++++++++++++++
 tb/tb_mem_access_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and widths for the memory access stage
//
// Purpose: FSM state enum, default datapath width and register-address width
// shared by the interface, the request FSM and the stage top.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW     = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack handshake bundle
//
// Purpose: groups the data-memory request and response signals.
// Ports (master = pipeline stage, slave = memory):
//   dmem_req   master->slave  memory request
//   dmem_we    master->slave  write enable
//   dmem_addr  master->slave  word-aligned byte address
//   dmem_wdata master->slave  store data
//   dmem_ack   slave->master  access complete, dmem_rdata valid this cycle
//   dmem_rdata slave->master  load data
interface mem_access_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_req_fsm.sv
// rtl/mem_access_stage_req_fsm.sv - data-memory request FSM with ack timeout
//
// Purpose: issues the memory request, tracks the wait for dmem_ack, aborts a
// request that waits too long and keeps sticky error flags.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mop             EX/MEM holds a valid load or store
//   mis             that access is misaligned (never requested)
//   dmem_ack        memory acknowledge
//   req             request to memory
//   stall           access outstanding, pipeline must freeze
//   abort           timeout terminal cycle
//   ack_ok          ack accepted for an active request this cycle
//   err_misaligned  sticky misaligned-access flag
//   err_timeout     sticky timeout flag
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mop,
  input  logic mis,
  input  logic dmem_ack,
  output logic req,
  output logic stall,
  output logic abort,
  output logic ack_ok,
  output logic err_misaligned,
  output logic err_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  // The counter holds the number of WAIT cycles already spent; the access
  // aborts when this cycle's increment would bring it to ACK_TIMEOUT-1, so the
  // request is held for ACK_TIMEOUT cycles in total, the last one aborting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 2);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_mis_q, err_mis_d;
  logic             err_to_q, err_to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_mis_d = err_mis_q | mis;
    err_to_d  = err_to_q;
    req       = 1'b0;
    abort     = 1'b0;
    ack_ok    = 1'b0;
    stall     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req = mop & ~mis;
        if (req && !dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        // EX/MEM is frozen while here, so req/addr/data/we stay stable.
        req   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort    = 1'b1;
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An ack without an active request is ignored.
    ack_ok = req & dmem_ack;
    stall  = req & ~dmem_ack & ~abort;
  end

  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM register, data-memory access and MEM/WB register
//
// Purpose: registers execute results, performs loads/stores over the dmem
// handshake, stalls while an access is outstanding, and produces the
// write-back value plus forwarding sources.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   ex_*                           execute-stage instruction fields
//   dmem                           data-memory handshake (master side)
//   mem_stall                      freezes IF/ID/EX and EX/MEM
//   ex_mem_alu_result/_reg_write/_write_reg       EX/MEM forwarding source
//   mem_wb_reg_write/_write_reg/_write_back_result MEM/WB outputs
//   err_misaligned, err_timeout    sticky error flags
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_reg_write,
  input  logic               ex_mem_to_reg,
  input  logic [REG_AW-1:0]  ex_write_reg,
  mem_access_stage_if.master dmem,
  output logic               mem_stall,
  output logic [DATA_W-1:0]  ex_mem_alu_result,
  output logic               ex_mem_reg_write,
  output logic [REG_AW-1:0]  ex_mem_write_reg,
  output logic               mem_wb_reg_write,
  output logic [REG_AW-1:0]  mem_wb_write_reg,
  output logic [DATA_W-1:0]  mem_wb_write_back_result,
  output logic               err_misaligned,
  output logic               err_timeout
);

  // EX/MEM register
  logic              exm_valid_q;
  logic [DATA_W-1:0] exm_alu_q;
  logic [DATA_W-1:0] exm_store_q;
  logic              exm_mem_read_q;
  logic              exm_mem_write_q;
  logic              exm_reg_write_q;
  logic              exm_mem_to_reg_q;
  logic [REG_AW-1:0] exm_write_reg_q;

  // MEM/WB register
  logic              mwb_valid_q;
  logic              mwb_reg_write_q;
  logic [REG_AW-1:0] mwb_write_reg_q;
  logic [DATA_W-1:0] mwb_result_q;

  logic              mop;
  logic              mis;
  logic              req;
  logic              stall;
  logic              abort;
  logic              ack_ok;
  logic [DATA_W-1:0] wb_result_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exm_valid_q      <= 1'b0;
      exm_alu_q        <= '0;
      exm_store_q      <= '0;
      exm_mem_read_q   <= 1'b0;
      exm_mem_write_q  <= 1'b0;
      exm_reg_write_q  <= 1'b0;
      exm_mem_to_reg_q <= 1'b0;
      exm_write_reg_q  <= '0;
    end else if (!stall) begin
      exm_valid_q      <= ex_valid;
      exm_alu_q        <= ex_alu_result;
      exm_store_q      <= ex_store_data;
      exm_mem_read_q   <= ex_mem_read;
      exm_mem_write_q  <= ex_mem_write;
      exm_reg_write_q  <= ex_reg_write;
      exm_mem_to_reg_q <= ex_mem_to_reg;
      exm_write_reg_q  <= ex_write_reg;
    end
  end

  assign mop = exm_valid_q & (exm_mem_read_q | exm_mem_write_q);
  assign mis = mop & (exm_alu_q[1:0] != 2'b00);

  mem_req_fsm #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_req_fsm (
    .clk            (clk),
    .rst_n          (reset),
    .mop            (mop),
    .mis            (mis),
    .dmem_ack       (dmem.dmem_ack),
    .req            (req),
    .stall          (stall),
    .abort          (abort),
    .ack_ok         (ack_ok),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout)
  );

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = exm_mem_write_q;
  assign dmem.dmem_addr  = exm_alu_q;
  assign dmem.dmem_wdata = exm_store_q;

  // Load data only counts when the access really completed; aborted or
  // misaligned loads write back zero.
  assign wb_result_d = exm_mem_to_reg_q ? (ack_ok ? dmem.dmem_rdata : '0) : exm_alu_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mwb_valid_q     <= 1'b0;
      mwb_reg_write_q <= 1'b0;
      mwb_write_reg_q <= '0;
      mwb_result_q    <= '0;
    end else if (stall) begin
      mwb_valid_q     <= 1'b0;
      mwb_reg_write_q <= 1'b0;
    end else begin
      mwb_valid_q     <= exm_valid_q;
      mwb_reg_write_q <= exm_reg_write_q;
      mwb_write_reg_q <= exm_write_reg_q;
      mwb_result_q    <= wb_result_d;
    end
  end

  assign mem_stall                = stall;
  assign ex_mem_alu_result        = exm_alu_q;
  assign ex_mem_reg_write         = exm_valid_q & exm_reg_write_q;
  assign ex_mem_write_reg         = exm_write_reg_q;
  assign mem_wb_reg_write         = mwb_valid_q & mwb_reg_write_q;
  assign mem_wb_write_reg         = mwb_write_reg_q;
  assign mem_wb_write_back_result = mwb_result_q;

  // abort only shapes stall inside the FSM; keep it visible for debug.
  logic unused_abort;
  assign unused_abort = abort;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_write_reg;
  logic        mem_stall;
  logic [31:0] ex_mem_alu_result;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_write_reg;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] mem_wb_write_back_result;
  logic        err_misaligned;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;

  mem_access_stage_if #(.DATA_W(32)) dif ();

  mem_access_stage #(
    .ACK_TIMEOUT (16),
    .DATA_W      (32)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .ex_valid                 (ex_valid),
    .ex_alu_result            (ex_alu_result),
    .ex_store_data            (ex_store_data),
    .ex_mem_read              (ex_mem_read),
    .ex_mem_write             (ex_mem_write),
    .ex_reg_write             (ex_reg_write),
    .ex_mem_to_reg            (ex_mem_to_reg),
    .ex_write_reg             (ex_write_reg),
    .dmem                     (dif),
    .mem_stall                (mem_stall),
    .ex_mem_alu_result        (ex_mem_alu_result),
    .ex_mem_reg_write         (ex_mem_reg_write),
    .ex_mem_write_reg         (ex_mem_write_reg),
    .mem_wb_reg_write         (mem_wb_reg_write),
    .mem_wb_write_reg         (mem_wb_write_reg),
    .mem_wb_write_back_result (mem_wb_write_back_result),
    .err_misaligned           (err_misaligned),
    .err_timeout              (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    ex_valid      = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_reg_write  = 1'b0;
    ex_mem_to_reg = 1'b0;
    ex_write_reg  = '0;
  endtask

  task automatic drive_op(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                          input logic wr, input logic rw, input logic m2r, input logic [4:0] rdst);
    ex_valid      = 1'b1;
    ex_alu_result = addr;
    ex_store_data = wdata;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
    ex_write_reg  = rdst;
  endtask

  initial begin
    int n;
    drive_nop();
    dif.dmem_ack   = 1'b0;
    dif.dmem_rdata = '0;

    // Reset state
    step();
    step();
    check("rst_req", 32'(dif.dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_exm_alu", ex_mem_alu_result, 32'd0);
    check("rst_wb", mem_wb_write_back_result, 32'd0);
    check("rst_errs", {30'd0, err_timeout, err_misaligned}, 32'd0);
    reset = 1'b1;
    step();

    // ALU passthrough
    drive_op(32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
    #1 check("alu_stall0", 32'(mem_stall), 32'd0);
    step();
    drive_nop();
    #1;
    check("alu_exm", ex_mem_alu_result, 32'h10);
    check("alu_exm_rw", {26'd0, ex_mem_reg_write, ex_mem_write_reg}, {26'd0, 1'b1, 5'd5});
    check("alu_stall1", 32'(mem_stall), 32'd0);
    step();
    check("alu_wb", mem_wb_write_back_result, 32'h10);
    check("alu_wb_rd", {26'd0, mem_wb_reg_write, mem_wb_write_reg}, {26'd0, 1'b1, 5'd5});

    // Zero-wait load
    drive_op(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    step();
    drive_nop();
    #1;
    check("zl_req", {31'd0, dif.dmem_req}, 32'd1);
    check("zl_addr", dif.dmem_addr, 32'h100);
    check("zl_we", 32'(dif.dmem_we), 32'd0);
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 32'hDEAD_BEEF;
    #1 check("zl_nostall", 32'(mem_stall), 32'd0);
    step();
    dif.dmem_ack = 1'b0;
    check("zl_wb", mem_wb_write_back_result, 32'hDEAD_BEEF);
    check("zl_wb_rd", {26'd0, mem_wb_reg_write, mem_wb_write_reg}, {26'd0, 1'b1, 5'd7});

    // Store with 3 wait cycles
    drive_op(32'h200, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drive_nop();
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("st_stall%0d", i), 32'(mem_stall), 32'd1);
      check($sformatf("st_req%0d", i), {31'd0, dif.dmem_req}, 32'd1);
      check($sformatf("st_we%0d", i), 32'(dif.dmem_we), 32'd1);
      check($sformatf("st_addr%0d", i), dif.dmem_addr, 32'h200);
      check($sformatf("st_wdata%0d", i), dif.dmem_wdata, 32'h1234_5678);
      step();
      check($sformatf("st_bubble%0d", i), 32'(mem_wb_reg_write), 32'd0);
      check($sformatf("st_exm_hold%0d", i), ex_mem_alu_result, 32'h200);
    end
    dif.dmem_ack = 1'b1;
    #1;
    check("st_ack_nostall", 32'(mem_stall), 32'd0);
    check("st_ack_req", {31'd0, dif.dmem_req}, 32'd1);
    step();
    dif.dmem_ack = 1'b0;
    #1;
    check("st_done_req", {31'd0, dif.dmem_req}, 32'd0);
    check("st_done_stall", 32'(mem_stall), 32'd0);

    // Timeout: load with no ack
    dif.dmem_rdata = 32'hFFFF_FFFF;
    drive_op(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    step();
    drive_nop();
    #1;
    n = 0;
    while (mem_stall === 1'b1 && n < 40) begin
      n++;
      step();
      #1;
    end
    check("to_stall_cycles", 32'(n), 32'd15);
    check("to_abort_req", {31'd0, dif.dmem_req}, 32'd1);
    step();
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_wb_zero", mem_wb_write_back_result, 32'd0);
    check("to_wb_rd", {26'd0, mem_wb_reg_write, mem_wb_write_reg}, {26'd0, 1'b1, 5'd9});
    check("to_req_idle", {31'd0, dif.dmem_req}, 32'd0);

    // Misaligned load, with a stray ack that must be ignored
    drive_op(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    step();
    drive_nop();
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 32'hCAFE_F00D;
    #1;
    check("mis_req", {31'd0, dif.dmem_req}, 32'd0);
    check("mis_stall", 32'(mem_stall), 32'd0);
    step();
    dif.dmem_ack = 1'b0;
    check("mis_err", 32'(err_misaligned), 32'd1);
    check("mis_wb_zero", mem_wb_write_back_result, 32'd0);
    check("mis_wb_rd", {26'd0, mem_wb_reg_write, mem_wb_write_reg}, {26'd0, 1'b1, 5'd3});
    check("to_err_sticky", 32'(err_timeout), 32'd1);

    // Reset while waiting, then a clean load
    drive_op(32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
    step();
    drive_nop();
    step();
    check("rw_wait_req", {31'd0, dif.dmem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("rw_req_drop", {31'd0, dif.dmem_req}, 32'd0);
    check("rw_stall", 32'(mem_stall), 32'd0);
    check("rw_errs", {30'd0, err_timeout, err_misaligned}, 32'd0);
    check("rw_exm", ex_mem_alu_result, 32'd0);
    check("rw_wb", mem_wb_write_back_result, 32'd0);
    step();
    reset = 1'b1;
    step();
    drive_op(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    step();
    drive_nop();
    #1;
    check("rl_req", {31'd0, dif.dmem_req}, 32'd1);
    check("rl_addr", dif.dmem_addr, 32'h300);
    step();
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 32'h0BAD_F00D;
    #1 check("rl_ack_nostall", 32'(mem_stall), 32'd0);
    step();
    dif.dmem_ack = 1'b0;
    check("rl_wb", mem_wb_write_back_result, 32'h0BAD_F00D);
    check("rl_wb_rd", {26'd0, mem_wb_reg_write, mem_wb_write_reg}, {26'd0, 1'b1, 5'd4});
    check("rl_errs", {30'd0, err_timeout, err_misaligned}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
